mw_bc_buffer: RTL and testbench



---
 rtl/matmul_pkg.sv | 40 ++++
 rtl/bc_bank.sv | 80 ++++++++
 rtl/mw_bc_buffer.sv | 155 +++++++++++++++
 tb/tb_mw_bc_buffer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul broadcast buffer.
package matmul_pkg;

  localparam int unsigned ELEN        = 64;
  localparam int unsigned MAX_BLEN    = 4;
  localparam int unsigned BC_LEN_W    = 16;
  localparam int unsigned BC_REPLAY_W = 8;

  typedef enum logic [1:0] {
    EW8  = 2'd0,
    EW16 = 2'd1,
    EW32 = 2'd2,
    EW64 = 2'd3
  } vew_e;

  typedef enum logic [1:0] {
    BK_EMPTY = 2'd0,
    BK_FILL  = 2'd1,
    BK_READY = 2'd2
  } bc_bank_state_e;

  // Per-broadcast configuration, sized for the largest supported widths.
  typedef struct packed {
    vew_e                   vsew;
    logic [BC_LEN_W-1:0]    len;
    logic [BC_REPLAY_W-1:0] replay;
  } bc_cfg_t;

  // Rows needed for len elements of width 8<<sew across lanes x ELEN-bit rows.
  function automatic logic [31:0] bc_rows_needed(input logic [BC_LEN_W-1:0] len,
                                                 input vew_e sew,
                                                 input int unsigned lanes);
    logic [31:0] k;
    logic [31:0] t;
    k = 32'd3 - 32'(sew);
    t = (32'(len) + (32'd1 << k) - 32'd1) >> k;
    return (t + lanes - 32'd1) / lanes;
  endfunction

endpackage

// File: rtl/bc_bank.sv
// One ping-pong bank: row storage, row write port, element-select read port,
// the latched configuration and the remaining-replay counter.
module bc_bank
  import matmul_pkg::*;
#(
  parameter int unsigned NrLanes     = 4,
  parameter int unsigned Depth       = MAX_BLEN,
  parameter int unsigned ReplayWidth = 4,
  parameter int unsigned LenWidth    = 8,
  localparam int unsigned RowW       = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cfg_we_i,
  input  bc_cfg_t                   cfg_i,
  input  logic                      row_we_i,
  input  logic [RowW-1:0]           row_addr_i,
  input  logic [NrLanes*ELEN-1:0]   row_data_i,
  input  logic [LenWidth-1:0]       elem_idx_i,
  input  logic                      rep_dec_i,
  output bc_cfg_t                   cfg_o,
  output logic [ReplayWidth-1:0]    rep_o,
  output logic [ELEN-1:0]           elem_o
);

  logic [NrLanes*ELEN-1:0] mem_q [Depth];
  bc_cfg_t                 cfg_q;
  logic [ReplayWidth-1:0]  rep_q;

  logic [31:0]             shamt;
  logic [31:0]             quo;
  logic [31:0]             lane;
  logic [31:0]             slot;
  logic [RowW-1:0]         row;
  logic [NrLanes*ELEN-1:0] row_data;
  logic [ELEN-1:0]         word;

  // Row storage: written one full row at a time, never reset.
  always_ff @(posedge clk_i) begin
    if (row_we_i) mem_q[row_addr_i] <= row_data_i;
  end

  // Configuration latch and replay counter for the broadcast held in this bank.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q <= '0;
      rep_q <= '0;
    end else if (cfg_we_i) begin
      cfg_q <= cfg_i;
      rep_q <= ReplayWidth'(cfg_i.replay);
    end else if (rep_dec_i) begin
      rep_q <= rep_q - 1'b1;
    end
  end

  // Element select: lane = e mod NrLanes, slot/row from e div NrLanes.
  always_comb begin
    shamt    = 32'd3 - 32'(cfg_q.vsew);
    quo      = 32'(elem_idx_i) / NrLanes;
    lane     = 32'(elem_idx_i) % NrLanes;
    slot     = quo & ((32'd1 << shamt) - 32'd1);
    row      = RowW'(quo >> shamt);
    row_data = mem_q[row];
    word     = '0;
    for (int unsigned l = 0; l < NrLanes; l++) begin
      if (lane == 32'(l)) word = row_data[l*ELEN +: ELEN];
    end
    word = word >> (slot << (32'd3 + 32'(cfg_q.vsew)));
    case (cfg_q.vsew)
      EW8:     elem_o = {{(ELEN-8){1'b0}}, word[7:0]};
      EW16:    elem_o = {{(ELEN-16){1'b0}}, word[15:0]};
      EW32:    elem_o = {{(ELEN-32){1'b0}}, word[31:0]};
      default: elem_o = word;
    endcase
  end

  assign cfg_o = cfg_q;
  assign rep_o = rep_q;

endmodule

// File: rtl/mw_bc_buffer.sv
// Ping-pong broadcast buffer: lanes fill one bank row by row while lane0
// drains another bank element by element, with optional replay passes.
module mw_bc_buffer
  import matmul_pkg::*;
#(
  parameter int unsigned NrLanes      = 4,
  parameter int unsigned NrBanks      = 2,
  parameter int unsigned Depth        = MAX_BLEN,
  parameter int unsigned ReplayWidth  = 4,
  localparam int unsigned LenWidth    = $clog2(Depth*NrLanes*8) + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NrLanes-1:0]                 ldu_result_req_i,
  input  logic [NrLanes-1:0][ELEN-1:0]       ldu_result_wdata_i,
  input  logic [NrLanes-1:0][ELEN/8-1:0]     ldu_result_be_i,
  output logic [NrLanes-1:0]                 ldu_result_gnt_o,
  output logic [NrLanes-1:0]                 ldu_result_final_gnt_o,
  input  logic                               cfg_valid_i,
  output logic                               cfg_ready_o,
  input  vew_e                               cfg_vsew_i,
  input  logic [LenWidth-1:0]                cfg_len_i,
  input  logic [ReplayWidth-1:0]             cfg_replay_i,
  output logic [ELEN-1:0]                    bc_data_o,
  output logic                               bc_data_valid_o,
  input  logic                               bc_data_ready_i,
  input  logic                               bc_data_invalidate_i
);

  localparam int unsigned BankW = $clog2(NrBanks);
  localparam int unsigned RowW  = (Depth > 1) ? $clog2(Depth) : 1;

  if (NrBanks < 2 || (NrBanks & (NrBanks - 1)) != 0) begin : g_bad_banks
    $error("mw_bc_buffer: NrBanks must be a power of two and at least 2");
  end
  if (LenWidth > BC_LEN_W || ReplayWidth > BC_REPLAY_W) begin : g_bad_widths
    $error("mw_bc_buffer: length or replay width exceeds bc_cfg_t fields");
  end

  bc_bank_state_e         bank_state_q [NrBanks];
  logic [BankW-1:0]       wr_ptr_q;
  logic [BankW-1:0]       rd_ptr_q;
  logic [LenWidth-1:0]    row_q;
  logic [LenWidth-1:0]    elem_q;

  bc_cfg_t                bank_cfg  [NrBanks];
  logic [ReplayWidth-1:0] bank_rep  [NrBanks];
  logic [ELEN-1:0]        bank_elem [NrBanks];

  bc_cfg_t                new_cfg;
  bc_cfg_t                wcfg;
  bc_cfg_t                rcfg;
  logic [ReplayWidth-1:0] rep_left;
  logic [31:0]            rows_needed;
  logic                   cfg_accept;
  logic                   row_gnt;
  logic                   last_row;
  logic                   rd_ready;
  logic                   pop;
  logic                   inval;
  logic                   last_elem;
  logic                   unused_be;
  logic                   unused_cfg;

  assign unused_be  = ^ldu_result_be_i;
  assign unused_cfg = ^{wcfg.replay, rcfg.vsew, rcfg.replay};

  assign new_cfg.vsew   = cfg_vsew_i;
  assign new_cfg.len    = BC_LEN_W'(cfg_len_i);
  assign new_cfg.replay = BC_REPLAY_W'(cfg_replay_i);

  assign wcfg     = bank_cfg[wr_ptr_q];
  assign rcfg     = bank_cfg[rd_ptr_q];
  assign rep_left = bank_rep[rd_ptr_q];

  // A zero-length config completes the handshake but is dropped.
  assign cfg_ready_o = (bank_state_q[wr_ptr_q] == BK_EMPTY);
  assign cfg_accept  = cfg_valid_i && cfg_ready_o && (cfg_len_i != '0);

  assign rows_needed = bc_rows_needed(wcfg.len, wcfg.vsew, NrLanes);
  assign row_gnt     = (bank_state_q[wr_ptr_q] == BK_FILL) && (&ldu_result_req_i);
  assign last_row    = (32'(row_q) + 32'd1) >= rows_needed;

  assign ldu_result_gnt_o       = {NrLanes{row_gnt}};
  assign ldu_result_final_gnt_o = {NrLanes{row_gnt}};

  assign rd_ready        = (bank_state_q[rd_ptr_q] == BK_READY);
  assign inval           = rd_ready && bc_data_invalidate_i;
  assign pop             = rd_ready && bc_data_ready_i && !bc_data_invalidate_i;
  assign last_elem       = (32'(elem_q) + 32'd1) == 32'(rcfg.len);
  assign bc_data_valid_o = rd_ready;
  assign bc_data_o       = bank_elem[rd_ptr_q];

  for (genvar b = 0; b < NrBanks; b++) begin : g_bank
    bc_bank #(
      .NrLanes    (NrLanes),
      .Depth      (Depth),
      .ReplayWidth(ReplayWidth),
      .LenWidth   (LenWidth)
    ) i_bank (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .cfg_we_i  (cfg_accept && (wr_ptr_q == BankW'(b))),
      .cfg_i     (new_cfg),
      .row_we_i  (row_gnt && (wr_ptr_q == BankW'(b))),
      .row_addr_i(RowW'(row_q)),
      .row_data_i(ldu_result_wdata_i),
      .elem_idx_i(elem_q),
      .rep_dec_i (pop && last_elem && (rep_left != '0) && (rd_ptr_q == BankW'(b))),
      .cfg_o     (bank_cfg[b]),
      .rep_o     (bank_rep[b]),
      .elem_o    (bank_elem[b])
    );
  end

  // Bank state machine plus fill-side and drain-side pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned b = 0; b < NrBanks; b++) bank_state_q[b] <= BK_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      row_q    <= '0;
      elem_q   <= '0;
    end else begin
      if (cfg_accept) bank_state_q[wr_ptr_q] <= BK_FILL;

      if (row_gnt) begin
        if (last_row) begin
          bank_state_q[wr_ptr_q] <= BK_READY;
          row_q    <= '0;
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end else begin
          row_q <= row_q + 1'b1;
        end
      end

      if (inval) begin
        bank_state_q[rd_ptr_q] <= BK_EMPTY;
        rd_ptr_q <= rd_ptr_q + 1'b1;
        elem_q   <= '0;
      end else if (pop) begin
        if (last_elem) begin
          elem_q <= '0;
          if (rep_left == '0) begin
            bank_state_q[rd_ptr_q] <= BK_EMPTY;
            rd_ptr_q <= rd_ptr_q + 1'b1;
          end
        end else begin
          elem_q <= elem_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mw_bc_buffer.sv
// Directed bench for mw_bc_buffer with default parameters (4 lanes, 2 banks).
module tb_mw_bc_buffer;
  import matmul_pkg::*;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b1;
  logic [3:0]        req = '0;
  logic [3:0][63:0]  wdata = '0;
  logic [3:0][7:0]   be = '1;
  logic [3:0]        gnt;
  logic [3:0]        fgnt;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  vew_e              cfg_vsew = EW8;
  logic [7:0]        cfg_len = '0;
  logic [3:0]        cfg_replay = '0;
  logic [63:0]       bc_data;
  logic              bc_valid;
  logic              bc_ready = 1'b0;
  logic              inval = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mw_bc_buffer dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .ldu_result_req_i      (req),
    .ldu_result_wdata_i    (wdata),
    .ldu_result_be_i       (be),
    .ldu_result_gnt_o      (gnt),
    .ldu_result_final_gnt_o(fgnt),
    .cfg_valid_i           (cfg_valid),
    .cfg_ready_o           (cfg_ready),
    .cfg_vsew_i            (cfg_vsew),
    .cfg_len_i             (cfg_len),
    .cfg_replay_i          (cfg_replay),
    .bc_data_o             (bc_data),
    .bc_data_valid_o       (bc_valid),
    .bc_data_ready_i       (bc_ready),
    .bc_data_invalidate_i  (inval)
  );

  // Lane i, slot j carries base + j*4 + i, truncated to the element width.
  function automatic logic [3:0][63:0] build_row(input vew_e s, input logic [63:0] base);
    logic [3:0][63:0] r;
    logic [63:0] mask;
    logic [63:0] v;
    int sew;
    sew  = 8 << int'(s);
    mask = (sew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sew) - 64'd1);
    r    = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 64 / sew; j++) begin
        v    = (base + 64'(j * 4 + i)) & mask;
        r[i] = r[i] | (v << (j * sew));
      end
    end
    return r;
  endfunction

  task automatic do_cfg(input vew_e s, input int l, input int r);
    @(negedge clk);
    cfg_valid  = 1'b1;
    cfg_vsew   = s;
    cfg_len    = 8'(l);
    cfg_replay = 4'(r);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic push_row(input vew_e s, input logic [63:0] base, output logic [3:0] g);
    @(negedge clk);
    req   = 4'hF;
    wdata = build_row(s, base);
    #1 g = gnt;
    @(posedge clk);
    #1 req = '0;
  endtask

  task automatic pop(output logic v, output logic [63:0] d);
    @(negedge clk);
    bc_ready = 1'b1;
    #1 v = bc_valid;
    d = bc_data;
    @(posedge clk);
    #1 bc_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready);
    end
    checks++;
    if (bc_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", bc_valid);
    end
    checks++;
    if (gnt !== 4'h0 || fgnt !== 4'h0) begin
      failures++; $display("FAIL reset_gnt got=%h/%h exp=0/0", gnt, fgnt);
    end
    @(negedge clk) rst_ni = 1'b1;
  endtask

  task automatic test_ew32_two_rows;
    logic [3:0] g;
    logic v;
    logic [63:0] d;
    do_cfg(EW32, 16, 0);
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++; $display("FAIL ew32_fill_cfg_ready got=%b exp=0", cfg_ready);
    end
    push_row(EW32, 64'd0, g);
    checks++;
    if (g !== 4'hF) begin failures++; $display("FAIL ew32_row0_gnt got=%h exp=f", g); end
    push_row(EW32, 64'd8, g);
    checks++;
    if (g !== 4'hF) begin failures++; $display("FAIL ew32_row1_gnt got=%h exp=f", g); end
    checks++;
    if (cfg_ready !== 1'b1 || bc_valid !== 1'b1) begin
      failures++; $display("FAIL ew32_after_fill got=%b%b exp=11", cfg_ready, bc_valid);
    end
    push_row(EW32, 64'd99, g);
    checks++;
    if (g !== 4'h0) begin failures++; $display("FAIL ew32_empty_bank_gnt got=%h exp=0", g); end
    for (int n = 0; n < 16; n++) begin
      pop(v, d);
      checks++;
      if (v !== 1'b1 || d !== 64'(n)) begin
        failures++; $display("FAIL ew32_pop%0d got=%b/%h exp=1/%h", n, v, d, 64'(n));
      end
    end
    checks++;
    if (bc_valid !== 1'b0) begin failures++; $display("FAIL ew32_drained got=%b exp=0", bc_valid); end
  endtask

  task automatic test_replay;
    logic [3:0] g;
    logic v;
    logic [63:0] d;
    do_cfg(EW16, 5, 2);
    push_row(EW16, 64'h100, g);
    checks++;
    if (g !== 4'hF) begin failures++; $display("FAIL replay_gnt got=%h exp=f", g); end
    push_row(EW16, 64'h200, g);
    checks++;
    if (g !== 4'h0) begin failures++; $display("FAIL replay_extra_gnt got=%h exp=0", g); end
    for (int n = 0; n < 15; n++) begin
      pop(v, d);
      checks++;
      if (v !== 1'b1 || d !== 64'h100 + 64'(n % 5)) begin
        failures++; $display("FAIL replay_pop%0d got=%b/%h exp=1/%h", n, v, d, 64'h100 + 64'(n % 5));
      end
    end
    checks++;
    if (bc_valid !== 1'b0) begin failures++; $display("FAIL replay_drained got=%b exp=0", bc_valid); end
  endtask

  task automatic test_zero_len;
    logic [3:0] g;
    do_cfg(EW32, 0, 0);
    checks++;
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL zero_len_cfg_ready got=%b exp=1", cfg_ready); end
    push_row(EW32, 64'd0, g);
    checks++;
    if (g !== 4'h0 || bc_valid !== 1'b0) begin
      failures++; $display("FAIL zero_len_no_fill got=%h/%b exp=0/0", g, bc_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] g;
    logic v;
    logic [63:0] d;
    logic [63:0] exp;
    do_cfg(EW64, 4, 0);
    push_row(EW64, 64'h1000, g);
    checks++;
    if (g !== 4'hF) begin failures++; $display("FAIL b2b_gnt0 got=%h exp=f", g); end
    do_cfg(EW64, 4, 0);
    push_row(EW64, 64'h2000, g);
    checks++;
    if (g !== 4'hF) begin failures++; $display("FAIL b2b_gnt1 got=%h exp=f", g); end
    checks++;
    if (cfg_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_cfg_ready got=%b exp=0", cfg_ready); end
    do_cfg(EW8, 3, 0);
    checks++;
    if (cfg_ready !== 1'b0 || bc_valid !== 1'b1 || bc_data !== 64'h1000) begin
      failures++; $display("FAIL b2b_hold got=%b/%b/%h exp=0/1/1000", cfg_ready, bc_valid, bc_data);
    end
    for (int n = 0; n < 8; n++) begin
      pop(v, d);
      exp = (n < 4) ? 64'h1000 + 64'(n) : 64'h2000 + 64'(n - 4);
      checks++;
      if (v !== 1'b1 || d !== exp) begin
        failures++; $display("FAIL b2b_pop%0d got=%b/%h exp=1/%h", n, v, d, exp);
      end
    end
    checks++;
    if (bc_valid !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_drained got=%b/%b exp=0/1", bc_valid, cfg_ready);
    end
  endtask

  task automatic test_invalidate;
    logic [3:0] g;
    logic v;
    logic [63:0] d;
    do_cfg(EW64, 8, 3);
    push_row(EW64, 64'h3000, g);
    push_row(EW64, 64'h3004, g);
    checks++;
    if (g !== 4'hF) begin failures++; $display("FAIL inv_fill_gnt got=%h exp=f", g); end
    do_cfg(EW64, 4, 0);
    push_row(EW64, 64'h4000, g);
    for (int n = 0; n < 3; n++) begin
      pop(v, d);
      checks++;
      if (v !== 1'b1 || d !== 64'h3000 + 64'(n)) begin
        failures++; $display("FAIL inv_pre_pop%0d got=%b/%h exp=1/%h", n, v, d, 64'h3000 + 64'(n));
      end
    end
    @(negedge clk);
    inval    = 1'b1;
    bc_ready = 1'b1;
    @(posedge clk);
    #1 inval = 1'b0;
    bc_ready = 1'b0;
    checks++;
    if (bc_valid !== 1'b1 || bc_data !== 64'h4000) begin
      failures++; $display("FAIL inv_next_bank got=%b/%h exp=1/4000", bc_valid, bc_data);
    end
    for (int n = 0; n < 4; n++) begin
      pop(v, d);
      checks++;
      if (v !== 1'b1 || d !== 64'h4000 + 64'(n)) begin
        failures++; $display("FAIL inv_post_pop%0d got=%b/%h exp=1/%h", n, v, d, 64'h4000 + 64'(n));
      end
    end
    checks++;
    if (bc_valid !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++; $display("FAIL inv_no_replay got=%b/%b exp=0/1", bc_valid, cfg_ready);
    end
  endtask

  task automatic test_reset_mid_fill;
    logic [3:0] g;
    logic v;
    logic [63:0] d;
    do_cfg(EW8, 128, 0);
    push_row(EW8, 64'h20, g);
    checks++;
    if (g !== 4'hF || cfg_ready !== 1'b0) begin
      failures++; $display("FAIL midrst_first_row got=%h/%b exp=f/0", g, cfg_ready);
    end
    @(negedge clk);
    req    = 4'hF;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'h0 || fgnt !== 4'h0 || cfg_ready !== 1'b1 || bc_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs got=%h/%h/%b/%b exp=0/0/1/0", gnt, fgnt, cfg_ready, bc_valid);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    req    = '0;
    do_cfg(EW8, 3, 1);
    push_row(EW8, 64'h10, g);
    checks++;
    if (g !== 4'hF) begin failures++; $display("FAIL midrst_fresh_gnt got=%h exp=f", g); end
    for (int n = 0; n < 6; n++) begin
      pop(v, d);
      checks++;
      if (v !== 1'b1 || d !== 64'h10 + 64'(n % 3)) begin
        failures++; $display("FAIL midrst_pop%0d got=%b/%h exp=1/%h", n, v, d, 64'h10 + 64'(n % 3));
      end
    end
    checks++;
    if (bc_valid !== 1'b0) begin failures++; $display("FAIL midrst_drained got=%b exp=0", bc_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ew32_two_rows();
    test_replay();
    test_zero_len();
    test_back_to_back();
    test_invalidate();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
